// File: rtl/ps2_key_event_tx.sv
`default_nettype none
// ============================================================================
// Module   : ps2_key_event_tx
// Brief    : Transmitter for the 11-bit ps2_key event bus
//            {toggle, pressed, extended, code[7:0]}. Queues key events from
//            any producer and emits each one as a toggle of bit 10, with a
//            minimum idle gap between emissions so a clk_sys consumer that
//            compares against its previous toggle never misses an event.
//            Optional macro PS2_KEY_TYPEMATIC_EN adds auto-repeat of the
//            most recently emitted make code.
// Revision : 1.0 - initial release
// ============================================================================
module ps2_key_event_tx #(
   parameter int FIFO_DEPTH   = 8,
   parameter int GAP_CYCLES   = 4,
   parameter int REPEAT_DELAY = 6000000,
   parameter int REPEAT_RATE  = 1200000
) (
   input  logic        clk_sys,
   input  logic        reset,
   input  logic        ev_valid,
   output logic        ev_ready,
   input  logic        ev_pressed,
   input  logic        ev_ext,
   input  logic [7:0]  ev_code,
   output logic [10:0] ps2_key,
   output logic        busy,
   output logic        overflow
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int GW = $clog2(GAP_CYCLES + 1);

   localparam logic [0:0] S_IDLE = 1'b0;
   localparam logic [0:0] S_GAP  = 1'b1;

   // Event queue storage; pointers carry one extra wrap bit.
   logic [9:0]    mem_q [FIFO_DEPTH];
   logic [AW:0]   wr_ptr_q;
   logic [AW:0]   rd_ptr_q;
   logic          overflow_q;

   logic [0:0]    state_q, state_d;
   logic [GW-1:0] gap_q, gap_d;
   logic [10:0]   key_q, key_d;

   logic          w_empty, w_full, w_push, w_pop;
   logic          w_emit;
   logic [9:0]    w_head;
   logic [9:0]    w_emit_data;

   assign w_empty = (wr_ptr_q == rd_ptr_q);
   assign w_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                    (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign w_push  = ev_valid && !w_full;
   assign w_head  = mem_q[rd_ptr_q[AW-1:0]];

`ifdef PS2_KEY_TYPEMATIC_EN
   localparam int RMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
   localparam int RW   = $clog2(RMAX + 1);

   logic          held_valid_q;
   logic          held_ext_q;
   logic [7:0]    held_code_q;
   logic [RW-1:0] rep_cnt_q;
   logic          w_repeat;

   // Repeat only when nothing is queued and the bus is idle; counter holds
   // the number of edges left before the repeat emission edge.
   assign w_repeat    = held_valid_q && (rep_cnt_q == '0) && (state_q == S_IDLE) && w_empty;
   assign w_emit      = w_pop || w_repeat;
   assign w_emit_data = w_pop ? w_head : {1'b1, held_ext_q, held_code_q};

   // Held-key tracking and repeat countdown.
   always_ff @(posedge clk_sys) begin
      if (reset) begin
         held_valid_q <= 1'b0;
         held_ext_q   <= 1'b0;
         held_code_q  <= '0;
         rep_cnt_q    <= '0;
      end else if (w_emit && w_emit_data[9]) begin
         held_valid_q <= 1'b1;
         held_ext_q   <= w_emit_data[8];
         held_code_q  <= w_emit_data[7:0];
         rep_cnt_q    <= w_repeat ? RW'(REPEAT_RATE - 1) : RW'(REPEAT_DELAY - 1);
      end else if (w_emit && held_valid_q && (w_emit_data[8] == held_ext_q) &&
                   (w_emit_data[7:0] == held_code_q)) begin
         held_valid_q <= 1'b0;
      end else if (held_valid_q && (rep_cnt_q != '0)) begin
         rep_cnt_q    <= rep_cnt_q - RW'(1);
      end
   end
`else
   logic w_unused_repeat;
   assign w_unused_repeat = ^{32'(REPEAT_DELAY), 32'(REPEAT_RATE)};
   assign w_emit          = w_pop;
   assign w_emit_data     = w_head;
`endif

   // Queue write side and sticky overflow flag.
   always_ff @(posedge clk_sys) begin
      if (reset) begin
         wr_ptr_q   <= '0;
         overflow_q <= 1'b0;
      end else begin
         if (w_push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= {ev_pressed, ev_ext, ev_code};
            wr_ptr_q                <= wr_ptr_q + (AW+1)'(1);
         end
         if (ev_valid && w_full) begin
            overflow_q <= 1'b1;
         end
      end
   end

   // Queue read side advances on every pop.
   always_ff @(posedge clk_sys) begin
      if (reset) begin
         rd_ptr_q <= '0;
      end else if (w_pop) begin
         rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
      end
   end

   // FSM state register.
   always_ff @(posedge clk_sys) begin
      if (reset) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // FSM next state: leave IDLE on an emission, leave GAP when count hits 0.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (w_emit) state_d = S_GAP;
         S_GAP:   if (gap_q == GW'(1)) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // FSM outputs: pop, gap counter and bus value for the next edge.
   always_comb begin
      w_pop = 1'b0;
      gap_d = gap_q;
      key_d = key_q;
      case (state_q)
         S_IDLE: begin
            w_pop = !w_empty;
            if (w_emit) begin
               key_d = {~key_q[10], w_emit_data};
               gap_d = GW'(GAP_CYCLES);
            end
         end
         S_GAP: begin
            gap_d = gap_q - GW'(1);
         end
         default: begin
            gap_d = '0;
         end
      endcase
   end

   // Bus and gap counter registers.
   always_ff @(posedge clk_sys) begin
      if (reset) begin
         key_q <= '0;
         gap_q <= '0;
      end else begin
         key_q <= key_d;
         gap_q <= gap_d;
      end
   end

   assign ps2_key  = key_q;
   assign ev_ready = !w_full;
   assign busy     = !w_empty || (state_q != S_IDLE);
   assign overflow = overflow_q;

endmodule
`default_nettype wire

// File: tb/tb_ps2_key_event_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_ps2_key_event_tx
// Brief    : Directed self-checking bench for ps2_key_event_tx
//            (FIFO_DEPTH=4, GAP_CYCLES=4, REPEAT_DELAY=20, REPEAT_RATE=10).
// Revision : 1.0 - initial release
// ============================================================================
module tb_ps2_key_event_tx;

   logic        clk_sys = 1'b0;
   logic        reset   = 1'b1;
   logic        ev_valid = 1'b0;
   logic        ev_ready;
   logic        ev_pressed = 1'b0;
   logic        ev_ext = 1'b0;
   logic [7:0]  ev_code = '0;
   logic [10:0] ps2_key;
   logic        busy;
   logic        overflow;

   int n_cmp = 0;
   int n_bad = 0;
   int cyc   = 0;

   int          log_edge [$];
   logic [10:0] log_key  [$];
   logic [10:0] prev_key = '0;

   ps2_key_event_tx #(
      .FIFO_DEPTH  (4),
      .GAP_CYCLES  (4),
      .REPEAT_DELAY(20),
      .REPEAT_RATE (10)
   ) dut (
      .clk_sys   (clk_sys),
      .reset     (reset),
      .ev_valid  (ev_valid),
      .ev_ready  (ev_ready),
      .ev_pressed(ev_pressed),
      .ev_ext    (ev_ext),
      .ev_code   (ev_code),
      .ps2_key   (ps2_key),
      .busy      (busy),
      .overflow  (overflow)
   );

   always #5 clk_sys = ~clk_sys;

   // Edge index: after a posedge, cyc names the edge that just occurred.
   always @(posedge clk_sys) cyc <= cyc + 1;

   // Record every bus change outside reset with the edge that produced it.
   always @(negedge clk_sys) begin
      if (reset) begin
         prev_key = ps2_key;
      end else if (ps2_key !== prev_key) begin
         log_edge.push_back(cyc);
         log_key.push_back(ps2_key);
         prev_key = ps2_key;
      end
   end

   task automatic step();
      @(negedge clk_sys);
      #1;
   endtask

   task automatic do_reset(input int n);
      ev_valid = 1'b0;
      reset    = 1'b1;
      repeat (n) step();
      reset    = 1'b0;
      log_edge.delete();
      log_key.delete();
   endtask

   // Offer one event across the next edge; report edge index and readiness.
   task automatic offer(input logic p, input logic e, input logic [7:0] c,
                        output int edge_n, output logic rdy);
      ev_valid   = 1'b1;
      ev_pressed = p;
      ev_ext     = e;
      ev_code    = c;
      rdy        = ev_ready;
      step();
      edge_n     = cyc;
      ev_valid   = 1'b0;
   endtask

   task automatic test_reset();
      do_reset(3);
      n_cmp++; if (ps2_key !== 11'h000) begin n_bad++; $display("FAIL reset_key got=%h want=000", ps2_key); end
      n_cmp++; if (ev_ready !== 1'b1) begin n_bad++; $display("FAIL reset_ready got=%b want=1", ev_ready); end
      n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got=%b want=0", busy); end
      n_cmp++; if (overflow !== 1'b0) begin n_bad++; $display("FAIL reset_ovf got=%b want=0", overflow); end
   endtask

   task automatic test_single();
      int n; logic r;
      do_reset(2);
      offer(1'b1, 1'b0, 8'h29, n, r);
      step();
      n_cmp++; if (ps2_key !== 11'h629) begin n_bad++; $display("FAIL single_key got=%h want=629", ps2_key); end
      n_cmp++; if (log_edge.size() != 1 || log_edge[0] != n + 1) begin
         n_bad++; $display("FAIL single_latency got_n=%0d want_edge=%0d", log_edge.size(), n + 1); end
      repeat (3) step();
      n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL single_busy_gap got=%b want=1", busy); end
      step();
      n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL single_busy_end got=%b want=0", busy); end
   endtask

   task automatic test_back_to_back();
      int n, d; logic r;
      logic [10:0] exp_k [3];
      exp_k = '{11'h775, 11'h175, 11'h66B};
      do_reset(2);
      offer(1'b1, 1'b1, 8'h75, n, r);
      offer(1'b0, 1'b1, 8'h75, d, r);
      offer(1'b1, 1'b0, 8'h6B, d, r);
      repeat (20) step();
      n_cmp++; if (log_key.size() != 3) begin n_bad++; $display("FAIL b2b_count got=%0d want=3", log_key.size()); end
      for (int i = 0; i < 3; i++) begin
         if (i < log_key.size()) begin
            n_cmp++; if (log_key[i] !== exp_k[i] || log_edge[i] != n + 1 + 5 * i) begin
               n_bad++; $display("FAIL b2b_ev%0d got=%h@%0d want=%h@%0d", i, log_key[i], log_edge[i], exp_k[i], n + 1 + 5 * i); end
         end
      end
   endtask

   task automatic test_overflow();
      int d; logic r;
      logic [7:0]  codes [6];
      logic [10:0] exp_k;
      codes = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
      do_reset(2);
      for (int i = 0; i < 6; i++) begin
         offer(1'b1, i[0], codes[i], d, r);
         if (i == 5) begin
            n_cmp++; if (r !== 1'b0) begin n_bad++; $display("FAIL ovf_ready6 got=%b want=0", r); end
         end else if (i == 4) begin
            n_cmp++; if (r !== 1'b1) begin n_bad++; $display("FAIL ovf_ready5 got=%b want=1", r); end
         end
      end
      n_cmp++; if (overflow !== 1'b1) begin n_bad++; $display("FAIL ovf_flag got=%b want=1", overflow); end
      repeat (35) step();
      n_cmp++; if (log_key.size() != 5) begin n_bad++; $display("FAIL ovf_count got=%0d want=5", log_key.size()); end
      for (int i = 0; i < 5; i++) begin
         exp_k = {~i[0], 1'b1, i[0], codes[i]};
         if (i < log_key.size()) begin
            n_cmp++; if (log_key[i] !== exp_k) begin
               n_bad++; $display("FAIL ovf_ev%0d got=%h want=%h", i, log_key[i], exp_k); end
         end
      end
      n_cmp++; if (overflow !== 1'b1) begin n_bad++; $display("FAIL ovf_sticky got=%b want=1", overflow); end
   endtask

   task automatic test_reset_mid();
      int d; logic r;
      do_reset(2);
      offer(1'b1, 1'b0, 8'h12, d, r);
      offer(1'b1, 1'b0, 8'h34, d, r);
      step();
      reset = 1'b1;
      step();
      n_cmp++; if (ps2_key !== 11'h000) begin n_bad++; $display("FAIL rstmid_key got=%h want=000", ps2_key); end
      n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rstmid_busy got=%b want=0", busy); end
      reset = 1'b0;
      repeat (20) step();
      n_cmp++; if (log_key.size() != 1 || log_key[0] !== 11'h612) begin
         n_bad++; $display("FAIL rstmid_toggles got_n=%0d want_n=1 (612)", log_key.size()); end
      n_cmp++; if (ps2_key !== 11'h000) begin n_bad++; $display("FAIL rstmid_hold got=%h want=000", ps2_key); end
   endtask

   task automatic test_typematic();
      int n, t, d; logic r;
      int          exp_e [$];
      logic [10:0] exp_k [$];
      do_reset(2);
      offer(1'b1, 1'b0, 8'h1C, n, r);
      t = n + 1;
      while (cyc < t + 45) step();
      offer(1'b0, 1'b0, 8'h1C, d, r);
      repeat (40) step();
`ifdef PS2_KEY_TYPEMATIC_EN
      exp_e = '{t, t + 20, t + 30, t + 40, d + 1};
      exp_k = '{11'h61C, 11'h21C, 11'h61C, 11'h21C, 11'h41C};
`else
      exp_e = '{t, d + 1};
      exp_k = '{11'h61C, 11'h01C};
`endif
      n_cmp++; if (log_key.size() != exp_k.size()) begin
         n_bad++; $display("FAIL tm_count got=%0d want=%0d", log_key.size(), exp_k.size()); end
      for (int i = 0; i < exp_k.size(); i++) begin
         if (i < log_key.size()) begin
            n_cmp++; if (log_key[i] !== exp_k[i] || log_edge[i] != exp_e[i]) begin
               n_bad++; $display("FAIL tm_ev%0d got=%h@%0d want=%h@%0d", i, log_key[i], log_edge[i], exp_k[i], exp_e[i]); end
         end
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_back_to_back();
      test_overflow();
      test_reset_mid();
      test_typematic();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
